s_stream_unpacker: RTL and testbench

//  Consumer end of the S-sequence fetch interface of SmithWaterman. Requests 128-bit packed S

---
 rtl/s_stream_unpacker_pkg.sv | 43 ++++
 rtl/s_stream_unpacker_buffer.sv | 109 ++++++++++
 rtl/s_stream_unpacker.sv | 123 ++++++++++++
 tb/tb_s_stream_unpacker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_stream_unpacker_pkg.sv
// Shared definitions for the S-sequence unpacker: widths, the "full word"
// count encoding, FSM states and the per-word tag kept beside each buffered word.
package s_stream_unpacker_pkg;

    localparam int PE_LOG         = 6;
    localparam int CHAR_BITS      = 2;
    localparam int WORD_BITS      = 128;
    localparam int CHARS_PER_WORD = WORD_BITS / CHAR_BITS;
    localparam int VALID_W        = PE_LOG + 1;
    localparam int IDX_W          = $clog2(CHARS_PER_WORD);

    // All-ones count marks a full 64-base word that is not the last one of S.
    localparam logic [VALID_W-1:0] S_VALID_FULL = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // What the buffer needs to know about a stored word: whether it ends S
    // and the index of its last valid base.
    typedef struct packed {
        logic             final_word;
        logic [IDX_W-1:0] last_idx;
    } word_tag_t;

    // A count is usable when it is the full-word marker or 1..CHARS_PER_WORD.
    function automatic logic count_legal(input logic [VALID_W-1:0] v);
        return (v == S_VALID_FULL) ||
               ((v != '0) && (v <= VALID_W'(CHARS_PER_WORD)));
    endfunction

    // Turn a legal source count into the stored tag.
    function automatic word_tag_t decode_tag(input logic [VALID_W-1:0] v);
        word_tag_t t;
        t.final_word = (v != S_VALID_FULL);
        t.last_idx   = t.final_word ? IDX_W'(v - VALID_W'(1))
                                    : IDX_W'(CHARS_PER_WORD - 1);
        return t;
    endfunction

endpackage

// File: rtl/s_stream_unpacker_buffer.sv
// Two-entry word FIFO for the S unpacker. Each slot holds one packed word and
// its tag; the head slot is read one base per accepted cycle. A word arriving
// in the same cycle the head slot frees may take that slot if the other one is
// still occupied.
module s_word_buffer
    import s_stream_unpacker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [WORD_BITS-1:0] wr_data,
    input  word_tag_t            wr_tag,
    input  logic                 rd_ready,
    output logic [CHAR_BITS-1:0] rd_char,
    output logic                 rd_valid,
    output logic                 rd_last,
    output logic                 wr_drop,
    output logic                 last_pop,
    output logic                 space_next
);

    logic [WORD_BITS-1:0] data_q [2];
    word_tag_t            tag_q  [2];
    logic [1:0]           full_q;
    logic                 head_q;
    logic [IDX_W-1:0]     idx_q;

    logic [1:0]           full_after_pop;
    logic [1:0]           full_d;
    logic                 head_d;
    logic [IDX_W-1:0]     idx_d;
    logic                 advance;
    logic                 pop;
    logic                 wr_slot;
    logic                 wr_accept;

    // Read side: head slot drives the current base and its last-of-S marker.
    always_comb begin
        rd_valid = full_q[head_q];
        rd_char  = '0;
        rd_last  = 1'b0;
        if (rd_valid) begin
            rd_char = data_q[head_q][{idx_q, 1'b0} +: CHAR_BITS];
            rd_last = tag_q[head_q].final_word && (idx_q == tag_q[head_q].last_idx);
        end
    end

    // Occupancy update: free the head on its last base, then place any new word.
    // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
    always_comb begin
        advance        = full_q[head_q] && rd_ready;
        pop            = advance && (idx_q == tag_q[head_q].last_idx);
        last_pop       = pop && tag_q[head_q].final_word;

        full_after_pop = full_q;
        if (pop) begin
            full_after_pop[head_q] = 1'b0;
        end

        // Empty buffer -> slot 0; one slot busy -> the other; both busy -> drop.
        wr_slot   = full_after_pop[0];
        wr_accept = wr_en && (full_after_pop != 2'b11);
        wr_drop   = wr_en && (full_after_pop == 2'b11);

        full_d = full_after_pop;
        if (wr_accept) begin
            full_d[wr_slot] = 1'b1;
        end

        // An empty buffer always points at slot 0, where the next word lands.
        head_d = pop ? ~head_q : head_q;
        if (full_after_pop == 2'b00) begin
            head_d = 1'b0;
        end

        idx_d = idx_q;
        if (pop) begin
            idx_d = '0;
        end else if (advance) begin
            idx_d = idx_q + IDX_W'(1);
        end

        space_next = ~&full_d;
    end

    // Slot flags, head pointer and base index; reset leaves the buffer empty.
    // NOTE: non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= '0;
            head_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            full_q <= full_d;
            head_q <= head_d;
            idx_q  <= idx_d;
        end
    end

    // Word storage.
    // NOTE: payload storage is not reset; the full flags alone say whether a slot holds data.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            data_q[wr_slot] <= wr_data;
            tag_q[wr_slot]  <= wr_tag;
        end
    end

endmodule

// File: rtl/s_stream_unpacker.sv
// S-sequence unpacker: requests packed S words from the source, keeps up to
// two of them in s_word_buffer and streams one 2-bit base per cycle to the
// PE-array front end. The top holds the pass FSM, request and error logic.
module s_stream_unpacker
    import s_stream_unpacker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_request_s,
    input  logic [WORD_BITS-1:0] i_s,
    input  logic [VALID_W-1:0]   i_s_valid,
    output logic [CHAR_BITS-1:0] o_char,
    output logic                 o_char_valid,
    output logic                 o_char_last,
    input  logic                 i_char_ready,
    output logic                 o_error
);

    state_e    state_q;
    state_e    state_d;
    logic      final_seen_q;
    logic      final_seen_d;
    logic      request_d;
    logic      error_d;

    logic      capture;
    logic      count_bad;
    logic      wr_en;
    word_tag_t wr_tag;
    logic      wr_drop;
    logic      last_pop;
    logic      space_next;

    // Qualify the source word: only taken while running, with a legal count,
    // and never once the final word of S is already held.
    always_comb begin
        capture   = (state_q == ST_RUN) && (i_s_valid != '0);
        count_bad = !count_legal(i_s_valid);
        wr_tag    = decode_tag(i_s_valid);
        wr_en     = capture && !count_bad && !final_seen_q;
    end

    s_word_buffer u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (i_s),
        .wr_tag     (wr_tag),
        .rd_ready   (i_char_ready),
        .rd_char    (o_char),
        .rd_valid   (o_char_valid),
        .rd_last    (o_char_last),
        .wr_drop    (wr_drop),
        .last_pop   (last_pop),
        .space_next (space_next)
    );

    // Pass sequencing and the outputs decoded from the current state.
    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (last_pop) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_busy  = 1'b1;
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next-cycle request, final-word tracking and sticky error.
    // The request looks at occupancy after this cycle's capture and pop, so it
    // drops the cycle after the last free slot is filled.
    always_comb begin
        final_seen_d = 1'b0;
        if (state_q == ST_RUN) begin
            final_seen_d = final_seen_q || (wr_en && !wr_drop && wr_tag.final_word);
        end
        request_d = (state_d == ST_RUN) && space_next && !final_seen_d;
        error_d   = o_error || (capture && (count_bad || final_seen_q || wr_drop));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered request, final-word flag and error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            final_seen_q <= 1'b0;
            o_request_s  <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            final_seen_q <= final_seen_d;
            o_request_s  <= request_d;
            o_error      <= error_d;
        end
    end

endmodule

// File: tb/tb_s_stream_unpacker.sv
// Self-checking bench for s_stream_unpacker. The reference is the S sequence
// itself: bases are expected in order, words are counted as sent and consumed,
// and the two-word buffering bounds the request and valid outputs.
module tb_s_stream_unpacker;
    import s_stream_unpacker_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_start;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_request_s;
    logic [WORD_BITS-1:0] i_s;
    logic [VALID_W-1:0]   i_s_valid;
    logic [CHAR_BITS-1:0] o_char;
    logic                 o_char_valid;
    logic                 o_char_last;
    logic                 i_char_ready;
    logic                 o_error;

    int                   checks = 0;
    int                   errors = 0;
    bit                   err_exp = 1'b0;
    logic [CHAR_BITS-1:0] s_mem [0:511];

    always #5 clk = ~clk;

    s_stream_unpacker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_request_s  (o_request_s),
        .i_s          (i_s),
        .i_s_valid    (i_s_valid),
        .o_char       (o_char),
        .o_char_valid (o_char_valid),
        .o_char_last  (o_char_last),
        .i_char_ready (i_char_ready),
        .o_error      (o_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int len);
        for (int i = 0; i < len; i++) begin
            s_mem[i] = CHAR_BITS'($urandom_range(0, 3));
        end
    endtask

    // Pack word w of an S sequence of length len; unused tail bases are junk.
    function automatic logic [WORD_BITS-1:0] make_word(input int w, input int len);
        logic [WORD_BITS-1:0] x;
        int                   b;
        x = '0;
        for (int k = 0; k < CHARS_PER_WORD; k++) begin
            b = w * CHARS_PER_WORD + k;
            x[k*CHAR_BITS +: CHAR_BITS] = (b < len) ? s_mem[b] : CHAR_BITS'($urandom_range(0, 3));
        end
        return x;
    endfunction

    function automatic logic [VALID_W-1:0] word_count(input int w, input int len);
        int nwords;
        nwords = (len + CHARS_PER_WORD - 1) / CHARS_PER_WORD;
        if (w == nwords - 1) return VALID_W'(len - w * CHARS_PER_WORD);
        return S_VALID_FULL;
    endfunction

    // One pass over an S sequence of length len.
    // rmode: 0 always ready, 1 toggling, 2 mostly ready, 3 mostly stalled.
    // gap: percent chance the source skips a request-high cycle.
    // inject: push one extra word while both slots are occupied.
    // rst_at: >0 pulls reset once that many bases have been accepted.
    task automatic run_pass(input int len, input int rmode, input int gap,
                            input bit inject, input int rst_at);
        int                   nwords;
        int                   pos;
        int                   widx;
        int                   consumed;
        int                   cyc;
        bit                   finished;
        bit                   injected;
        bit                   aborted;
        bit                   hold;
        bit                   send;
        bit                   inj_now;
        bit                   acc;
        bit                   ready;
        bit                   reset_now;
        logic [CHAR_BITS-1:0] held_char;
        logic                 held_last;

        nwords   = (len + CHARS_PER_WORD - 1) / CHARS_PER_WORD;
        pos      = 0;
        widx     = 0;
        consumed = 0;
        cyc      = 0;
        finished = 0;
        injected = 0;
        aborted  = 0;
        hold     = 0;
        held_char = '0;
        held_last = 1'b0;

        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);

        while (!finished && !aborted && cyc < 20000) begin
            cyc++;
            // Observe the cycle.
            check("char_valid", o_char_valid, (widx - consumed) > 0);
            check("request", o_request_s, ((widx - consumed) < 2) && (widx < nwords));
            check("error", o_error, err_exp);
            check("done_low", o_done, 0);
            check("busy_run", o_busy, 1);
            if (widx > consumed) begin
                check("char", o_char, s_mem[pos]);
                check("char_last", o_char_last, pos == len - 1);
            end
            if (hold) begin
                check("hold_char", o_char, held_char);
                check("hold_last", o_char_last, held_last);
            end

            // Drive the next edge.
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 2) == 1;
                2:       ready = $urandom_range(0, 3) != 0;
                default: ready = $urandom_range(0, 3) == 0;
            endcase
            send    = o_request_s && (widx < nwords) && ($urandom_range(0, 99) >= gap);
            inj_now = inject && !injected && ((widx - consumed) == 2);
            if (inj_now) begin
                ready = 1'b0;
                send  = 1'b0;
            end
            i_char_ready = ready;
            i_s          = {4{$urandom()}};
            i_s_valid    = '0;
            if (send) begin
                i_s       = make_word(widx, len);
                i_s_valid = word_count(widx, len);
            end else if (inj_now) begin
                i_s_valid = S_VALID_FULL;
            end
            i_start   = ($urandom_range(0, 7) == 0);
            reset_now = (rst_at > 0) && (pos >= rst_at);
            if (reset_now) rst_n = 1'b0;
            acc       = (widx > consumed) && ready;
            hold      = (widx > consumed) && !ready;
            held_char = o_char;
            held_last = o_char_last;

            tick();

            if (reset_now) begin
                check("rst_busy", o_busy, 0);
                check("rst_done", o_done, 0);
                check("rst_request", o_request_s, 0);
                check("rst_char_valid", o_char_valid, 0);
                check("rst_char", o_char, 0);
                check("rst_char_last", o_char_last, 0);
                check("rst_error", o_error, 0);
                rst_n   = 1'b1;
                err_exp = 1'b0;
                aborted = 1;
            end else begin
                if (send) widx++;
                if (inj_now) begin
                    injected = 1;
                    err_exp  = 1'b1;
                end
                if (acc) begin
                    pos++;
                    if ((pos % CHARS_PER_WORD) == 0 || pos == len) consumed++;
                    if (pos == len) finished = 1;
                end
            end
        end

        i_start      = 1'b0;
        i_s_valid    = '0;
        i_char_ready = 1'b0;
        if (!aborted) begin
            check("pass_finished", finished, 1);
            check("done_pulse", o_done, 1);
            check("request_in_done", o_request_s, 0);
            check("valid_in_done", o_char_valid, 0);
            tick();
            check("done_cleared", o_done, 0);
            check("busy_cleared", o_busy, 0);
            check("error_after_pass", o_error, err_exp);
        end
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_s          = '0;
        i_s_valid    = '0;
        i_char_ready = 1'b0;
        repeat (3) tick();
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_request", o_request_s, 0);
        check("reset_char", o_char, 0);
        check("reset_char_valid", o_char_valid, 0);
        check("reset_char_last", o_char_last, 0);
        check("reset_error", o_error, 0);
        rst_n = 1'b1;
        tick();
        check("idle_request", o_request_s, 0);
        check("idle_busy", o_busy, 0);

        // Length 130: full, full, count 2.
        fill(130);
        run_pass(130, 0, 0, 1'b0, 0);

        // A word offered while idle is ignored and is not an error.
        i_s       = {4{$urandom()}};
        i_s_valid = S_VALID_FULL;
        tick();
        i_s_valid = '0;
        tick();
        check("idle_word_no_valid", o_char_valid, 0);
        check("idle_word_no_error", o_error, 0);
        check("idle_word_no_busy", o_busy, 0);

        // Length 64: a single full final word.
        fill(64);
        run_pass(64, 0, 0, 1'b0, 0);

        // Length 1: one base of value 3.
        fill(1);
        s_mem[0] = 2'b11;
        run_pass(1, 0, 0, 1'b0, 0);

        // Ready toggling every cycle over 200 bases.
        fill(200);
        run_pass(200, 1, 0, 1'b0, 0);

        // Extra word while both slots are occupied.
        fill(256);
        run_pass(256, 3, 10, 1'b1, 0);

        // Reset in the middle of a pass, then a fresh pass from base 0.
        fill(300);
        run_pass(300, 2, 20, 1'b0, 70);
        fill(150);
        run_pass(150, 2, 20, 1'b0, 0);

        // Random lengths, ready patterns and source gaps.
        for (int p = 0; p < 6; p++) begin
            n = $urandom_range(1, 400);
            fill(n);
            run_pass(n, $urandom_range(0, 3), $urandom_range(0, 50), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
